// File: rtl/sa_skew_feeder.sv
// sa_skew_feeder: operand feeder for an N x N output-stationary systolic array.
// Buffers one A and one B matrix (loaded element by element), then on start
// drives the diagonally skewed wavefront onto the array edges, flushes with
// zeros for DRAIN_CYC cycles and pulses done.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   wr_en/wr_sel  buffer write strobe and select (0 = A, 1 = B), IDLE only
//   wr_addr       element index row*N + col
//   wr_data       signed element value
//   start         begin a feed sequence (sampled only in IDLE)
//   busy          high in FEED and DRAIN
//   feed_valid    high while the lanes carry skewed data
//   a_lanes       lane i feeds a_in of array row i
//   b_lanes       lane j feeds b_in of array column j
//   done          one-cycle completion pulse
module sa_skew_feeder #(
    parameter int unsigned N         = 4,
    parameter int unsigned DW        = 16,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [2*$clog2(N)-1:0]    wr_addr,
    input  logic [DW-1:0]             wr_data,
    input  logic                      start,
    output logic                      busy,
    output logic                      feed_valid,
    output logic [N*DW-1:0]           a_lanes,
    output logic [N*DW-1:0]           b_lanes,
    output logic                      done
);

    localparam int unsigned AW        = 2 * $clog2(N);
    localparam int unsigned TW        = $clog2(2 * N + DRAIN_CYC);
    localparam int unsigned FEED_LAST = 2 * N - 2;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   t;
    logic [TW-1:0]   t_nxt;
    logic [DW-1:0]   a_buf [N*N];
    logic [DW-1:0]   b_buf [N*N];
    logic [N*DW-1:0] a_nxt;
    logic [N*DW-1:0] b_nxt;

    // Next state; t counts feed beats in FEED and flush cycles in DRAIN.
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FEED;
                    t_nxt     = '0;
                end
            end
            FEED: begin
                if (t == TW'(FEED_LAST)) begin
                    state_nxt = DRAIN;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + TW'(1);
                end
            end
            DRAIN: begin
                if (t == TW'(DRAIN_CYC - 1)) begin
                    state_nxt = DONE;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + TW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Skewed lane values for the beat about to be registered:
    // lane i carries A[i][t-i] and B[t-i][i] inside the diagonal window.
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        if (state_nxt == FEED) begin
            for (int i = 0; i < int'(N); i++) begin
                if ((int'(t_nxt) >= i) && ((int'(t_nxt) - i) < int'(N))) begin
                    a_nxt[i*DW +: DW] = a_buf[AW'(i * int'(N) + int'(t_nxt) - i)];
                    b_nxt[i*DW +: DW] = b_buf[AW'((int'(t_nxt) - i) * int'(N) + i)];
                end
            end
        end
    end

    // State, beat counter and registered outputs (outputs follow next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            t          <= '0;
            busy       <= 1'b0;
            feed_valid <= 1'b0;
            done       <= 1'b0;
            a_lanes    <= '0;
            b_lanes    <= '0;
        end else begin
            state      <= state_nxt;
            t          <= t_nxt;
            busy       <= (state_nxt == FEED) || (state_nxt == DRAIN);
            feed_valid <= (state_nxt == FEED);
            done       <= (state_nxt == DONE);
            a_lanes    <= a_nxt;
            b_lanes    <= b_nxt;
        end
    end

    // Operand buffers; start in the same cycle takes priority over a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N * N); k++) begin
                a_buf[k] <= '0;
                b_buf[k] <= '0;
            end
        end else if ((state == IDLE) && wr_en && !start) begin
            if (wr_sel) begin
                b_buf[wr_addr] <= wr_data;
            end else begin
                a_buf[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Testbench for sa_skew_feeder (N=4, DW=16, DRAIN_CYC=4): table-driven
// cycle vectors for two back-to-back runs plus directed corner sequences.
module tb_sa_skew_feeder;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        busy;
    logic        feed_valid;
    logic [63:0] a_lanes;
    logic [63:0] b_lanes;
    logic        done;

    int n_chk;
    int n_fail;

    sa_skew_feeder #(.N(4), .DW(16), .DRAIN_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .feed_valid (feed_valid),
        .a_lanes    (a_lanes),
        .b_lanes    (b_lanes),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        wr_en;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [63:0] a;
        logic [63:0] b;
        logic        fv;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t        tbl [26];
    logic [63:0] a_beat [7];
    logic [63:0] b_beat [7];

    function automatic logic [63:0] lanes4(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = 16'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk(nm, 64'(done), 64'd1);
    endtask

    initial begin
        int c;
        int ndone;
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;

        // Hand-computed beats for A[i][j]=4i+j+1, B=identity.
        a_beat[0] = lanes4(1, 0, 0, 0);
        a_beat[1] = lanes4(2, 5, 0, 0);
        a_beat[2] = lanes4(3, 6, 9, 0);
        a_beat[3] = lanes4(4, 7, 10, 13);
        a_beat[4] = lanes4(0, 8, 11, 14);
        a_beat[5] = lanes4(0, 0, 12, 15);
        a_beat[6] = lanes4(0, 0, 0, 16);
        for (int t = 0; t < 7; t++) b_beat[t] = '0;
        b_beat[0] = lanes4(1, 0, 0, 0);
        b_beat[2] = lanes4(0, 1, 0, 0);
        b_beat[4] = lanes4(0, 0, 1, 0);
        b_beat[6] = lanes4(0, 0, 0, 1);

        // Two 13-cycle runs: 7 feed, 4 drain, 1 done, 1 idle.
        for (int k = 0; k < 26; k++) begin
            c = k % 13;
            tbl[k] = '{start: 1'b0, wr_en: 1'b0, addr: 4'd0, data: 16'd0,
                       a: '0, b: '0, fv: 1'b0, busy: 1'b0, done: 1'b0};
            if (c < 7) begin
                tbl[k].a    = a_beat[c];
                tbl[k].b    = b_beat[c];
                tbl[k].fv   = 1'b1;
                tbl[k].busy = 1'b1;
            end else if (c < 11) begin
                tbl[k].busy = 1'b1;
            end else if (c == 11) begin
                tbl[k].done = 1'b1;
            end
        end
        tbl[2].wr_en  = 1'b1;   // write A[0][0]=99 during FEED: ignored
        tbl[2].data   = 16'd99;
        tbl[8].start  = 1'b1;   // start during DRAIN: ignored
        tbl[11].start = 1'b1;   // start in DONE: ignored
        tbl[12].start = 1'b1;   // start+write in first IDLE after done
        tbl[12].wr_en = 1'b1;
        tbl[12].data  = 16'd77;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fv", 64'(feed_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_a", a_lanes, 64'd0);
        chk("rst_b", b_lanes, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                load(1'b0, 4 * i + j, 4 * i + j + 1);
        for (int i = 0; i < 4; i++) load(1'b1, 5 * i, 1);
        chk("idle_busy", 64'(busy), 64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 26; k++) begin
            chk($sformatf("v%0d_a", k), a_lanes, tbl[k].a);
            chk($sformatf("v%0d_b", k), b_lanes, tbl[k].b);
            chk($sformatf("v%0d_fv", k), 64'(feed_valid), 64'(tbl[k].fv));
            chk($sformatf("v%0d_busy", k), 64'(busy), 64'(tbl[k].busy));
            chk($sformatf("v%0d_done", k), 64'(done), 64'(tbl[k].done));
            start   = tbl[k].start;
            wr_en   = tbl[k].wr_en;
            wr_sel  = 1'b0;
            wr_addr = tbl[k].addr;
            wr_data = tbl[k].data;
            tick();
        end
        start = 1'b0;
        wr_en = 1'b0;

        // Write dropped when issued together with start
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rerun_t0_a", a_lanes, a_beat[0]);
        wait_done("rerun_done");
        tick();

        // Signed pass-through, bit-exact
        load(1'b0, 9, 32'hFFFF_8000);
        load(1'b1, 12, 16'h7FFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("sgn_a2", 64'(a_lanes[47:32]), 64'h8000);
        chk("sgn_b0", 64'(b_lanes[15:0]), 64'h7FFF);
        chk("sgn_a0", 64'(a_lanes[15:0]), 64'd4);
        wait_done("sgn_done");
        tick();

        // Reset at beat t=2
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_a", a_lanes, a_beat[2]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_fv", 64'(feed_valid), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_a", a_lanes, 64'd0);
        chk("mid_rst_b", b_lanes, 64'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        chk("no_done_after_abort", 64'(ndone), 64'd0);

        // Cleared buffers stream zeros
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("zero_fv%0d", k), 64'(feed_valid), 64'd1);
            chk($sformatf("zero_a%0d", k), a_lanes, 64'd0);
            chk($sformatf("zero_b%0d", k), b_lanes, 64'd0);
            tick();
        end
        chk("zero_drain_fv", 64'(feed_valid), 64'd0);
        wait_done("zero_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Operand feeder placed directly upstream of the N x N systolic array built from the signed 16-bit PE tiles.
- Buffers one N x N A matrix and one N x N B matrix, loaded one element at a time from the PCPI-side loader.
- On start, drives the array's west edge (a lanes) and north edge (b lanes) with the diagonally skewed wavefront an output-stationary array needs.
- When the skewed feed ends, drives zeros to flush the array, then pulses done.

Parameters:
- N, 4, array dimension; power of two, >= 2.
- DW, 16, operand width; signed two's complement.
- DRAIN_CYC, 4, zero-feed cycles after the last skewed beat; must be >= N.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write one buffer element this cycle
- wr_sel  in  1  0 = A buffer, 1 = B buffer
- wr_addr  in  2*log2(N)  element index, row*N + col
- wr_data  in  DW  signed element value
- start  in  1  begin a feed sequence; sampled only in IDLE
- busy  out  1  high in FEED and DRAIN
- feed_valid  out  1  high while the lanes carry skewed data
- a_lanes  out  N*DW  lane i at bits [i*DW +: DW] feeds a_in of array row i
- b_lanes  out  N*DW  lane j at bits [j*DW +: DW] feeds b_in of array column j
- done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (synchronous, active-high, wins over every other input):
  - State goes to IDLE.
  - busy, feed_valid and done go to 0.
  - a_lanes and b_lanes go to 0.
  - Both buffers are cleared to 0.
  - Beat counter t goes to 0.
- All outputs are registered. No output has a combinational path from any input.
- Buffer writes:
  - Accepted only in IDLE, when wr_en=1 and start=0.
  - wr_en=1 in any other state is ignored.
  - start=1 together with wr_en=1 in IDLE: start wins and the write is dropped.
- States:
  - IDLE -> FEED on start=1.
  - FEED -> DRAIN when t = 2N-2.
  - DRAIN -> DONE after DRAIN_CYC cycles.
  - DONE -> IDLE unconditionally after one cycle.
- Timing of a run:
  - The edge that accepts start also registers beat t=0.
  - Beat t=0 appears on the outputs in the cycle after that edge.
  - Each later cycle advances t by 1.
- Skew rule at beat t:
  - a lane i = A[i][t-i] when 0 <= t-i < N, otherwise 0.
  - b lane j = B[t-j][j] when 0 <= t-j < N, otherwise 0.
- FEED:
  - Lasts exactly 2N-1 cycles, t = 0 .. 2N-2.
  - feed_valid=1 and busy=1 throughout.
- DRAIN:
  - All lanes 0, feed_valid=0, busy=1.
  - Lasts DRAIN_CYC cycles.
- DONE:
  - done=1 for exactly one cycle; busy=0 and lanes 0 in that cycle.
- IDLE: lanes 0, busy=0, done=0.
- Start handling:
  - start outside IDLE is ignored. It is not queued.
  - start in the DONE cycle is also ignored. A new run needs start in IDLE.
- Buffers keep their contents across runs, so a re-start without reloading repeats the same stream.
- Data widths: values pass to the lanes unchanged. There is no arithmetic and no sign extension.
- Reset during FEED or DRAIN:
  - Next cycle is IDLE with all outputs 0.
  - done is never pulsed for the aborted run.
  - Buffers read back as 0.
- Total run length, from the first feed_valid cycle through the done cycle: 2N-1 + DRAIN_CYC + 1 cycles. With the defaults this is 12.

Test Plan:
- Skew pattern:
  - Stimulus: N=4; load A[i][j] = 4i+j+1, B = identity; pulse start.
  - Beat t=0: a lanes = {1,0,0,0}. Beat t=3: a lanes = {4,7,10,13}. Beat t=6: a lanes = {0,0,0,16}.
  - b lane j is 1 only at t = 2j.
  - feed_valid is high for 7 cycles.
- Drain and done: from the same run, the cycle after the last feed_valid starts 4 zero cycles with busy=1. done=1 on the 12th cycle after the first feed_valid, with busy=0.
- Signed pass-through: A[2][1] = -32768 and B[3][0] = 0x7FFF. Required: a lane 2 = 0x8000 at t=3 and b lane 0 = 0x7FFF at t=3, bit-exact.
- Ignored inputs:
  - wr_en with A[0][0]=99 during FEED: a repeat run still shows A[0][0]=1.
  - start during DRAIN: no second run; exactly one done pulse.
  - start and wr_en together in IDLE: the write is dropped and the run starts.
- Reset mid-run: rst=1 at t=2. Next cycle: all outputs 0 and state IDLE; no done pulse; a new start with no reload streams all-zero lanes.
- Back-to-back runs: start asserted in the first IDLE cycle after done. The second run's t=0 values match the first run's.
